team_06_wb_arbiter: RTL and testbench
=====================================

Name: team_06_wb_arbiter

Overview:
Shares the single Wishbone master port of the team_06 design between two internal requesters. Requester 0 is the audio sample path (ADC/DAC buffers) and requester 1 is the display/SPI path. The arbiter grants round-robin, runs one classic single-beat Wishbone cycle per grant, and aborts hung cycles with a timeout. It sits between team_06_top's datapath engines and the ADR_O/DAT_O/SEL_O/WE_O/STB_O/CYC_O/DAT_I/ACK_I pins.

Parameters:
TIMEOUT, 255, cycles waited for ACK_I before aborting; must be at least 1; counter width is $clog2(TIMEOUT+1).

Ports:
clk  input  1  system clock; single clock domain; all logic rising-edge.
nrst  input  1  asynchronous active-low reset.
en  input  1  enable; low blocks new grants.
r0_req  input  1  requester 0 transaction request; held until r0_ack or r0_err.
r0_adr  input  32  requester 0 byte address.
r0_wdat  input  32  requester 0 write data.
r0_sel  input  4  requester 0 byte selects.
r0_we  input  1  requester 0 write (1) / read (0).
r0_ack  output  1  one-cycle completion pulse to requester 0.
r0_err  output  1  one-cycle timeout pulse to requester 0.
r1_req, r1_adr, r1_wdat, r1_sel, r1_we  input  1/32/32/4/1  requester 1, same meaning as requester 0.
r1_ack, r1_err  output  1/1  requester 1, same meaning as requester 0.
rdat  output  32  read data captured from DAT_I; shared by both requesters.
busy  output  1  high whenever the state is not IDLE.
gnt  output  1  index of the current or most recent grant.
ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O  output  32/32/4/1/1/1  Wishbone master outputs.
DAT_I, ACK_I  input  32/1  Wishbone slave response.

Behaviour:
- Reset (nrst low, asynchronous):
  - state=IDLE; all outputs 0; rdat=0; timeout counter=0.
  - last_gnt=1, so requester 0 wins the first tie.
  - Reset asserted mid-cycle drops CYC_O/STB_O immediately; no ack or err is issued.
- States: IDLE, BUS, DONE.
- IDLE:
  - If en=1 and any req is high, grant and latch that requester's adr/wdat/sel/we into internal registers.
  - Grant rule: if only one req is high, that requester wins; if both are high, grant !last_gnt.
  - Update gnt and last_gnt; clear the counter; go to BUS.
  - With en=0, stay in IDLE.
- BUS:
  - CYC_O=STB_O=1; ADR_O/DAT_O/SEL_O/WE_O come from the latched registers and stay stable for the whole cycle.
  - Requester inputs are ignored once latched.
  - ACK_I=1: capture DAT_I into rdat (on reads only; writes leave rdat unchanged); set the granted requester's ack register; go to DONE.
  - ACK_I=0: increment the counter. When the counter reaches TIMEOUT, set the granted requester's err register; go to DONE.
  - ACK_I arriving in the same cycle the counter reaches TIMEOUT counts as a success (ack, not err).
- DONE:
  - CYC_O=STB_O=0; the rx_ack or rx_err pulse is high for exactly this one cycle; next state is IDLE.
  - The requester drops or refreshes req at this edge. A req still high in IDLE is treated as a new transaction.
- Outputs outside BUS: ADR_O/DAT_O/SEL_O/WE_O return to 0.
- Latency:
  - req sampled high in IDLE at cycle N gives CYC_O=1 at cycle N+1.
  - ACK_I at cycle M gives rx_ack at cycle M+1 and CYC_O=0 at cycle M+1.
  - Minimum turnaround is 3 cycles per transaction. Back-to-back requests alternate when both requesters are continuously high.
- en falling during BUS or DONE: the transaction completes normally; no new grant follows.
- rdat holds its value until the next read ACK.
- CYC_O and STB_O are always equal; at most one ack/err pulse is high per cycle.

Test Plan:
- Single read: r0_req=1, r0_adr=0x3000_0010, r0_we=0; slave ACKs 2 cycles after STB_O with DAT_I=0xDEAD_BEEF -> ADR_O=0x3000_0010 and CYC_O=1 for 3 cycles; r0_ack pulses 1 cycle; rdat=0xDEAD_BEEF; r1_ack=0.
- Single write: r1_req=1, adr=0x3000_0020, wdat=0x1234_5678, sel=0xF, we=1; immediate ACK -> DAT_O=0x1234_5678, WE_O=1; r1_ack pulses; rdat unchanged.
- Contention: both req held high for 4 transactions after reset, 0-wait ACKs -> grant order 0,1,0,1; gnt matches each cycle; no overlapping acks.
- Timeout: TIMEOUT=4, r0 read with ACK_I held 0 -> CYC_O high exactly 5 cycles, then r0_err pulse, r0_ack=0; the next r1 request is served normally.
- Reset mid-cycle: nrst low during BUS -> CYC_O/STB_O/ADR_O go to 0 asynchronously; no ack; after release, a tie goes to requester 0.
- Enable gating: en=0 with r0_req=1 for 10 cycles -> CYC_O stays 0. Raise en -> CYC_O=1 on the next cycle. Drop en during BUS -> the transaction completes with r0_ack.

Source files
------------

// File: rtl/team_06_wb_arbiter_if.sv
// Classic single-beat Wishbone master/slave signal bundle for the team_06 arbiter.
interface team_06_wb_arbiter_if;
  logic [31:0] ADR_O;
  logic [31:0] DAT_O;
  logic [3:0]  SEL_O;
  logic        WE_O;
  logic        STB_O;
  logic        CYC_O;
  logic [31:0] DAT_I;
  logic        ACK_I;

  modport master (
    output ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O,
    input  DAT_I, ACK_I
  );

  modport slave (
    input  ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O,
    output DAT_I, ACK_I
  );
endinterface

// File: rtl/team_06_wb_arbiter.sv
// Two-requester round-robin arbiter for the team_06 Wishbone master port:
// one single-beat cycle per grant, hung cycles aborted after TIMEOUT idle beats.
module team_06_wb_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        en,

  input  logic        r0_req,
  input  logic [31:0] r0_adr,
  input  logic [31:0] r0_wdat,
  input  logic [3:0]  r0_sel,
  input  logic        r0_we,
  output logic        r0_ack,
  output logic        r0_err,

  input  logic        r1_req,
  input  logic [31:0] r1_adr,
  input  logic [31:0] r1_wdat,
  input  logic [3:0]  r1_sel,
  input  logic        r1_we,
  output logic        r1_ack,
  output logic        r1_err,

  output logic [31:0] rdat,
  output logic        busy,
  output logic        gnt,

  team_06_wb_arbiter_if.master wb
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_gnt;
  logic             win;

  // A lone requester always wins; a tie goes to whoever was not served last.
  always_comb begin
    win = 1'b0;
    if (r0_req && r1_req) begin
      win = ~last_gnt;
    end else if (r1_req) begin
      win = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      cnt       <= '0;
      last_gnt  <= 1'b1;
      gnt       <= 1'b0;
      busy      <= 1'b0;
      rdat      <= '0;
      r0_ack    <= 1'b0;
      r0_err    <= 1'b0;
      r1_ack    <= 1'b0;
      r1_err    <= 1'b0;
      wb.CYC_O  <= 1'b0;
      wb.STB_O  <= 1'b0;
      wb.ADR_O  <= '0;
      wb.DAT_O  <= '0;
      wb.SEL_O  <= '0;
      wb.WE_O   <= 1'b0;
    end else begin
      r0_ack <= 1'b0;
      r0_err <= 1'b0;
      r1_ack <= 1'b0;
      r1_err <= 1'b0;

      case (state)
        IDLE: begin
          if (en && (r0_req || r1_req)) begin
            state    <= BUS;
            busy     <= 1'b1;
            gnt      <= win;
            last_gnt <= win;
            cnt      <= '0;
            wb.CYC_O <= 1'b1;
            wb.STB_O <= 1'b1;
            wb.ADR_O <= win ? r1_adr  : r0_adr;
            wb.DAT_O <= win ? r1_wdat : r0_wdat;
            wb.SEL_O <= win ? r1_sel  : r0_sel;
            wb.WE_O  <= win ? r1_we   : r0_we;
          end
        end

        // An ACK in the same beat the counter hits TIMEOUT still wins over the abort.
        BUS: begin
          if (wb.ACK_I || (cnt == CNT_MAX)) begin
            state    <= DONE;
            wb.CYC_O <= 1'b0;
            wb.STB_O <= 1'b0;
            wb.ADR_O <= '0;
            wb.DAT_O <= '0;
            wb.SEL_O <= '0;
            wb.WE_O  <= 1'b0;
            if (wb.ACK_I) begin
              if (!wb.WE_O) begin
                rdat <= wb.DAT_I;
              end
              if (gnt) begin
                r1_ack <= 1'b1;
              end else begin
                r0_ack <= 1'b1;
              end
            end else if (gnt) begin
              r1_err <= 1'b1;
            end else begin
              r0_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (nrst) begin
      assert (wb.CYC_O == wb.STB_O);
      assert ($countones({r0_ack, r0_err, r1_ack, r1_err}) <= 1);
    end
  end
`endif

endmodule

// File: tb/tb_team_06_wb_arbiter.sv
// Self-checking bench for team_06_wb_arbiter: directed vector table, corner-case
// sequences, then random traffic against a transaction-level arbitration model.
module tb_team_06_wb_arbiter;

  localparam int TO = 4;

  logic        clk;
  logic        nrst;
  logic        en;
  logic        r0_req, r0_we, r0_ack, r0_err;
  logic [31:0] r0_adr, r0_wdat;
  logic [3:0]  r0_sel;
  logic        r1_req, r1_we, r1_ack, r1_err;
  logic [31:0] r1_adr, r1_wdat;
  logic [3:0]  r1_sel;
  logic [31:0] rdat;
  logic        busy;
  logic        gnt;

  team_06_wb_arbiter_if wb ();

  team_06_wb_arbiter #(.TIMEOUT(TO)) dut (
    .clk     (clk),
    .nrst    (nrst),
    .en      (en),
    .r0_req  (r0_req),
    .r0_adr  (r0_adr),
    .r0_wdat (r0_wdat),
    .r0_sel  (r0_sel),
    .r0_we   (r0_we),
    .r0_ack  (r0_ack),
    .r0_err  (r0_err),
    .r1_req  (r1_req),
    .r1_adr  (r1_adr),
    .r1_wdat (r1_wdat),
    .r1_sel  (r1_sel),
    .r1_we   (r1_we),
    .r1_ack  (r1_ack),
    .r1_err  (r1_err),
    .rdat    (rdat),
    .busy    (busy),
    .gnt     (gnt),
    .wb      (wb)
  );

  typedef struct {
    logic        req;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        we;
    int          delay;
    logic [31:0] dat;
    logic        exp_ok;
    int          exp_cyc;
    logic [31:0] exp_rdat;
  } vec_t;

  vec_t        vecs [6];
  int          checks = 0;
  int          failures = 0;
  logic        last_win;
  logic [31:0] m_rdat;
  bit          pend [2];
  logic [31:0] m_adr [2];
  logic [31:0] m_wdat [2];
  logic [3:0]  m_sel [2];
  logic        m_we [2];
  logic        exp_order [5];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic idx, input logic [31:0] adr, input logic [31:0] wdat,
                               input logic [3:0] sel, input logic we);
    if (idx) begin
      r1_req = 1'b1; r1_adr = adr; r1_wdat = wdat; r1_sel = sel; r1_we = we;
    end else begin
      r0_req = 1'b1; r0_adr = adr; r0_wdat = wdat; r0_sel = sel; r0_we = we;
    end
  endtask

  task automatic drop_req(input logic idx);
    if (idx) r1_req = 1'b0;
    else     r0_req = 1'b0;
  endtask

  task automatic new_req(input int r);
    pend[r]   = 1'b1;
    m_adr[r]  = $urandom;
    m_wdat[r] = $urandom;
    m_sel[r]  = 4'($urandom);
    m_we[r]   = 1'($urandom);
    applyStimulus(1'(r), m_adr[r], m_wdat[r], m_sel[r], m_we[r]);
  endtask

  // Called at a falling edge while the arbiter is IDLE with the request(s) already driven.
  task automatic run_txn(input string tag, input int delay, input logic [31:0] dat,
                         input bit drop_en, input bit keep, input logic exp_win,
                         input logic [31:0] exp_adr, input logic [31:0] exp_wdat,
                         input logic [3:0] exp_sel, input logic exp_we,
                         input bit exp_ok, input int exp_cyc, input logic [31:0] exp_rdat);
    int          wait_n;
    int          cyc_n;
    bit          stable;
    logic [31:0] a0, d0;
    logic [3:0]  s0;
    logic        w0;
    wait_n = 0;
    @(negedge clk);
    while (!wb.CYC_O && wait_n < 8) begin
      @(negedge clk);
      wait_n++;
    end
    checkOutput({tag, ".latency"}, wait_n, 0);
    checkOutput({tag, ".gnt"}, gnt, exp_win);
    checkOutput({tag, ".adr"}, wb.ADR_O, exp_adr);
    checkOutput({tag, ".dat_o"}, wb.DAT_O, exp_wdat);
    checkOutput({tag, ".sel"}, wb.SEL_O, exp_sel);
    checkOutput({tag, ".we"}, wb.WE_O, exp_we);
    a0 = wb.ADR_O; d0 = wb.DAT_O; s0 = wb.SEL_O; w0 = wb.WE_O;
    if (drop_en) en = 1'b0;
    if (!keep) begin
      if (exp_win) begin
        r1_adr = ~r1_adr; r1_wdat = $urandom; r1_sel = ~r1_sel; r1_we = ~r1_we;
      end else begin
        r0_adr = ~r0_adr; r0_wdat = $urandom; r0_sel = ~r0_sel; r0_we = ~r0_we;
      end
    end
    cyc_n  = 0;
    stable = 1'b1;
    while (wb.CYC_O && cyc_n < TO + 4) begin
      if (wb.ADR_O !== a0 || wb.DAT_O !== d0 || wb.SEL_O !== s0 || wb.WE_O !== w0 ||
          wb.STB_O !== 1'b1 || gnt !== exp_win || busy !== 1'b1)
        stable = 1'b0;
      wb.ACK_I = (cyc_n == delay);
      wb.DAT_I = (cyc_n == delay) ? dat : $urandom;
      cyc_n++;
      @(negedge clk);
    end
    wb.ACK_I = 1'b0;
    checkOutput({tag, ".cyc_len"}, cyc_n, exp_cyc);
    checkOutput({tag, ".stable"}, stable, 1'b1);
    checkOutput({tag, ".stb_done"}, wb.STB_O, 1'b0);
    checkOutput({tag, ".ack"}, exp_win ? r1_ack : r0_ack, exp_ok);
    checkOutput({tag, ".err"}, exp_win ? r1_err : r0_err, !exp_ok);
    checkOutput({tag, ".other"}, exp_win ? (r0_ack | r0_err) : (r1_ack | r1_err), 1'b0);
    checkOutput({tag, ".rdat"}, rdat, exp_rdat);
    checkOutput({tag, ".busy_done"}, busy, 1'b1);
    if (!keep) drop_req(exp_win);
    @(negedge clk);
    checkOutput({tag, ".idle_pulses"}, {r0_ack, r0_err, r1_ack, r1_err}, 4'b0000);
    checkOutput({tag, ".idle_busy"}, busy, 1'b0);
    checkOutput({tag, ".idle_bus"}, {wb.CYC_O, wb.ADR_O, wb.DAT_O, wb.SEL_O, wb.WE_O}, 32'h0);
  endtask

  initial begin
    logic        w;
    int          d;
    int          cyc;
    bit          ok;
    logic [31:0] dat;

    vecs[0] = '{1'b0, 32'h3000_0010, 32'h0000_0000, 4'hF, 1'b0, 2, 32'hDEAD_BEEF, 1'b1, 3, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h3000_0020, 32'h1234_5678, 4'hF, 1'b1, 0, 32'hFFFF_FFFF, 1'b1, 1, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 32'h3000_0030, 32'h0000_0000, 4'hF, 1'b0, 4, 32'hA5A5_0001, 1'b1, 5, 32'hA5A5_0001};
    vecs[3] = '{1'b0, 32'h3000_0034, 32'h0000_0000, 4'hF, 1'b0, 5, 32'h1111_2222, 1'b0, 5, 32'hA5A5_0001};
    vecs[4] = '{1'b1, 32'h3000_0040, 32'hCAFE_F00D, 4'h3, 1'b1, 1, 32'h0000_0000, 1'b1, 2, 32'hA5A5_0001};
    vecs[5] = '{1'b1, 32'h3000_0044, 32'h0000_0000, 4'hC, 1'b0, 0, 32'h0BAD_C0DE, 1'b1, 1, 32'h0BAD_C0DE};
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    nrst = 1'b1; en = 1'b1;
    r0_req = 1'b0; r0_adr = '0; r0_wdat = '0; r0_sel = '0; r0_we = 1'b0;
    r1_req = 1'b0; r1_adr = '0; r1_wdat = '0; r1_sel = '0; r1_we = 1'b0;
    wb.ACK_I = 1'b0; wb.DAT_I = '0;
    pend = '{1'b0, 1'b0};
    #1 nrst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst.cyc", wb.CYC_O, 1'b0);
    checkOutput("rst.stb", wb.STB_O, 1'b0);
    checkOutput("rst.adr", wb.ADR_O, 32'h0);
    checkOutput("rst.busy", busy, 1'b0);
    checkOutput("rst.gnt", gnt, 1'b0);
    checkOutput("rst.rdat", rdat, 32'h0);
    checkOutput("rst.pulses", {r0_ack, r0_err, r1_ack, r1_err}, 4'b0000);
    nrst = 1'b1;
    $display("[TB] directed vector table");

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].req, vecs[i].adr, vecs[i].wdat, vecs[i].sel, vecs[i].we);
      run_txn($sformatf("vec%0d", i), vecs[i].delay, vecs[i].dat, 1'b0, 1'b0, vecs[i].req,
              vecs[i].adr, vecs[i].wdat, vecs[i].sel, vecs[i].we,
              vecs[i].exp_ok, vecs[i].exp_cyc, vecs[i].exp_rdat);
    end
    last_win = vecs[5].req;
    m_rdat   = vecs[5].exp_rdat;

    $display("[TB] enable gating");
    en = 1'b0;
    applyStimulus(1'b0, 32'h3000_0050, 32'h5555_AAAA, 4'hF, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("en_low%0d.cyc", i), wb.CYC_O, 1'b0);
    end
    en = 1'b1;
    run_txn("en_drop", 1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h3000_0050, 32'h5555_AAAA, 4'hF, 1'b1,
            1'b1, 2, m_rdat);
    applyStimulus(1'b1, 32'h3000_0054, 32'h0, 4'hF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("en_hold%0d.busy", i), {wb.CYC_O, busy}, 2'b00);
    end
    en = 1'b1;
    m_rdat = 32'h7777_0003;
    run_txn("en_resume", 3, 32'h7777_0003, 1'b0, 1'b0, 1'b1, 32'h3000_0054, 32'h0, 4'hF, 1'b0,
            1'b1, 4, m_rdat);

    $display("[TB] reset during bus cycle");
    applyStimulus(1'b0, 32'h3000_0060, 32'h0, 4'hF, 1'b0);
    @(negedge clk);
    checkOutput("rst_mid.cyc_before", wb.CYC_O, 1'b1);
    #2 nrst = 1'b0;
    #1;
    checkOutput("rst_mid.cyc", wb.CYC_O, 1'b0);
    checkOutput("rst_mid.stb", wb.STB_O, 1'b0);
    checkOutput("rst_mid.adr", wb.ADR_O, 32'h0);
    checkOutput("rst_mid.busy", busy, 1'b0);
    drop_req(1'b0);
    @(negedge clk);
    checkOutput("rst_mid.pulses", {r0_ack, r0_err, r1_ack, r1_err}, 4'b0000);
    checkOutput("rst_mid.rdat", rdat, 32'h0);
    nrst = 1'b1;
    m_rdat = 32'h0;

    $display("[TB] contention");
    applyStimulus(1'b0, 32'h3000_0100, 32'h0101_0101, 4'hF, 1'b1);
    applyStimulus(1'b1, 32'h3000_0200, 32'h0202_0202, 4'h5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      w = exp_order[i];
      run_txn($sformatf("cont%0d", i), 0, 32'h0, 1'b0, (i < 3), w,
              w ? 32'h3000_0200 : 32'h3000_0100, w ? 32'h0202_0202 : 32'h0101_0101,
              w ? 4'h5 : 4'hF, 1'b1, 1'b1, 1, m_rdat);
    end
    last_win = 1'b0;

    $display("[TB] random traffic");
    for (int t = 0; t < 150; t++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 1) == 1) new_req(r);
      end
      if (!pend[0] && !pend[1]) new_req(int'($urandom_range(0, 1)));
      w   = (pend[0] && pend[1]) ? ~last_win : (pend[1] ? 1'b1 : 1'b0);
      d   = int'($urandom_range(0, TO + 1));
      dat = $urandom;
      ok  = (d <= TO);
      cyc = ok ? d + 1 : TO + 1;
      if (ok && !m_we[int'(w)]) m_rdat = dat;
      run_txn($sformatf("rnd%0d", t), d, dat, 1'b0, 1'b0, w, m_adr[int'(w)], m_wdat[int'(w)],
              m_sel[int'(w)], m_we[int'(w)], ok, cyc, m_rdat);
      pend[int'(w)] = 1'b0;
      last_win = w;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
